// File: rtl/game_pkg.sv
// Shared game constants: game-state codes, player poses, coordinate width and
// screen limits. Imported by the player controller and the display/draw blocks.
package game_pkg;

  localparam int COORD_W         = 9;
  localparam int SCREEN_W        = 320;
  localparam int SCREEN_H        = 240;
  localparam int SPRITE_W        = 16;
  localparam int HURT_HOLD_TICKS = 8;

  typedef enum logic [3:0] {
    GS_TITLE    = 4'd0,
    GS_STAFF    = 4'd1,
    GS_STAGE1   = 4'd2,
    GS_SUCCESS1 = 4'd3,
    GS_STAGE2   = 4'd4,
    GS_SUCCESS2 = 4'd5,
    GS_STAGE3   = 4'd6,
    GS_SUCCESS3 = 4'd7,
    GS_FAIL     = 4'd8
  } game_state_e;

  typedef enum logic [2:0] {
    POSE_IDLE  = 3'd0,
    POSE_UP    = 3'd1,
    POSE_DOWN  = 3'd2,
    POSE_LEFT  = 3'd3,
    POSE_RIGHT = 3'd4,
    POSE_HURT  = 3'd5,
    POSE_DEAD  = 3'd6
  } pose_e;

  function automatic logic is_stage(input logic [3:0] s);
    return (s == GS_STAGE1) || (s == GS_STAGE2) || (s == GS_STAGE3);
  endfunction

endpackage

// File: rtl/player_move_step.sv
// Combinational one-step mover: applies the requested direction(s) unless the
// matching wall flag is set, computes in 10 bits and clamps to the play field.
module player_move_step
  import game_pkg::*;
#(
  parameter int STEP  = 2,
  parameter int MAX_X = SCREEN_W - SPRITE_W,
  parameter int MAX_Y = SCREEN_H - SPRITE_W
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               go_up_i,
  input  logic               go_down_i,
  input  logic               go_left_i,
  input  logic               go_right_i,
  input  logic               blk_up_i,
  input  logic               blk_down_i,
  input  logic               blk_left_i,
  input  logic               blk_right_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  localparam logic [9:0] STEP10  = 10'(STEP);
  localparam logic [9:0] MAX_X10 = 10'(MAX_X);
  localparam logic [9:0] MAX_Y10 = 10'(MAX_Y);

  logic [9:0] x_ext, y_ext, x_sum, y_sum;

  always_comb begin
    x_ext = {1'b0, x_i};
    y_ext = {1'b0, y_i};
    x_sum = x_ext;
    y_sum = y_ext;
    // Subtraction saturates at 0 instead of wrapping.
    if (go_up_i && !blk_up_i)          y_sum = (y_ext < STEP10) ? 10'd0 : y_ext - STEP10;
    else if (go_down_i && !blk_down_i) y_sum = y_ext + STEP10;
    if (go_left_i && !blk_left_i)        x_sum = (x_ext < STEP10) ? 10'd0 : x_ext - STEP10;
    else if (go_right_i && !blk_right_i) x_sum = x_ext + STEP10;
    if (x_sum > MAX_X10) x_sum = MAX_X10;
    if (y_sum > MAX_Y10) y_sum = MAX_Y10;
    x_o = x_sum[COORD_W-1:0];
    y_o = y_sum[COORD_W-1:0];
  end

endmodule

// File: rtl/player_ctrl.sv
// Player controller: position, pose/animation, hit points and invincibility.
// Define DIAGONAL_MOVE_EN to apply a vertical and a horizontal step together.
module player_ctrl
  import game_pkg::*;
#(
  parameter int START_X     = 16,
  parameter int START_Y     = 200,
  parameter int STEP        = 2,
  parameter int MAX_X       = SCREEN_W - SPRITE_W,
  parameter int MAX_Y       = SCREEN_H - SPRITE_W,
  parameter int ANIM_TICKS  = 8,
  parameter int INV_TICKS   = 60,
  parameter int HEARTS_INIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         state,
  input  logic               frame_tick,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               blk_up,
  input  logic               blk_down,
  input  logic               blk_left,
  input  logic               blk_right,
  input  logic               hit,
  output logic [COORD_W-1:0] player_x,
  output logic [COORD_W-1:0] player_y,
  output logic [3:0]         player_state,
  output logic [1:0]         heart,
  output logic               dead
);

  localparam int ANIM_W = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam int INV_W  = $clog2(INV_TICKS + 1);
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_TICKS - 1);

  logic [3:0]         state_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, step_x, step_y;
  pose_e              pose_q, pose_d, walk_pose;
  logic               phase_q, phase_d, dead_q, dead_d;
  logic [ANIM_W-1:0]  anim_q, anim_d, anim_base;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic [1:0]         heart_q, heart_d;
  logic               stage_now, stage_entry, hurt_hold;
  logic               go_up, go_down, go_left, go_right;

  assign stage_now   = is_stage(state);
  assign stage_entry = stage_now && (state != state_q);
  // HURT covers the first HURT_HOLD_TICKS frames of the invincibility window.
  assign hurt_hold   = (inv_q > INV_W'(INV_TICKS - HURT_HOLD_TICKS));

`ifdef DIAGONAL_MOVE_EN
  logic v_moves;
  always_comb begin
    go_up     = key_up;
    go_down   = !key_up && key_down;
    go_left   = key_left;
    go_right  = !key_left && key_right;
    v_moves   = (go_up && !blk_up) || (go_down && !blk_down);
    walk_pose = POSE_IDLE;
    if ((go_up || go_down) && (v_moves || !(go_left || go_right)))
      walk_pose = go_up ? POSE_UP : POSE_DOWN;
    else if (go_left)  walk_pose = POSE_LEFT;
    else if (go_right) walk_pose = POSE_RIGHT;
  end
`else
  always_comb begin
    go_up     = key_up;
    go_down   = !key_up && key_down;
    go_left   = !key_up && !key_down && key_left;
    go_right  = !key_up && !key_down && !key_left && key_right;
    walk_pose = POSE_IDLE;
    if (go_up)         walk_pose = POSE_UP;
    else if (go_down)  walk_pose = POSE_DOWN;
    else if (go_left)  walk_pose = POSE_LEFT;
    else if (go_right) walk_pose = POSE_RIGHT;
  end
`endif

  player_move_step #(
    .STEP (STEP),
    .MAX_X(MAX_X),
    .MAX_Y(MAX_Y)
  ) u_step (
    .x_i        (x_q),
    .y_i        (y_q),
    .go_up_i    (go_up),
    .go_down_i  (go_down),
    .go_left_i  (go_left),
    .go_right_i (go_right),
    .blk_up_i   (blk_up),
    .blk_down_i (blk_down),
    .blk_left_i (blk_left),
    .blk_right_i(blk_right),
    .x_o        (step_x),
    .y_o        (step_y)
  );

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    pose_d    = pose_q;
    phase_d   = phase_q;
    anim_d    = anim_q;
    anim_base = anim_q;
    inv_d     = inv_q;
    heart_d   = heart_q;
    dead_d    = 1'b0;
    if (stage_entry) begin
      x_d     = COORD_W'(START_X);
      y_d     = COORD_W'(START_Y);
      pose_d  = POSE_IDLE;
      phase_d = 1'b0;
      anim_d  = '0;
      inv_d   = '0;
      heart_d = 2'(HEARTS_INIT);
    end else if (stage_now && pose_q != POSE_DEAD) begin
      if (hit && inv_q == '0) begin
        heart_d = heart_q - 2'd1;
        inv_d   = INV_W'(INV_TICKS);
        pose_d  = POSE_HURT;
        phase_d = 1'b0;
        anim_d  = '0;
        if (heart_q == 2'd1) begin
          pose_d = POSE_DEAD;
          dead_d = 1'b1;
        end
      end else if (frame_tick) begin
        if (inv_q != '0) inv_d = inv_q - INV_W'(1);
        if (!hurt_hold) begin
          pose_d = walk_pose;
          if (walk_pose == POSE_IDLE) begin
            phase_d = 1'b0;
            anim_d  = '0;
          end else begin
            x_d = step_x;
            y_d = step_y;
            // A new facing restarts the phase count with this tick as the first.
            if (walk_pose != pose_q) anim_base = '0;
            if (anim_base == ANIM_LAST) begin
              anim_d  = '0;
              phase_d = !phase_q;
            end else begin
              anim_d = anim_base + ANIM_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GS_TITLE;
      x_q     <= COORD_W'(START_X);
      y_q     <= COORD_W'(START_Y);
      pose_q  <= POSE_IDLE;
      phase_q <= 1'b0;
      anim_q  <= '0;
      inv_q   <= '0;
      heart_q <= 2'(HEARTS_INIT);
      dead_q  <= 1'b0;
    end else begin
      state_q <= state;
      x_q     <= x_d;
      y_q     <= y_d;
      pose_q  <= pose_d;
      phase_q <= phase_d;
      anim_q  <= anim_d;
      inv_q   <= inv_d;
      heart_q <= heart_d;
      dead_q  <= dead_d;
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = {phase_q, pose_q};
  assign heart        = heart_q;
  assign dead         = dead_q;

endmodule
